// File: rtl/icache_refill_axi_if.sv
// ---------------------------------------------------------------------------
// icache_refill_axi_if
//   AXI4 read-address and read-data channel bundle used between the icache
//   refill engine and the AXI crossbar.
//
//   Signals:
//     arid/araddr/arlen/arsize/arburst/arvalid  AR channel, master -> slave
//     arready                                   AR channel, slave -> master
//     rdata/rresp/rlast/rvalid                  R channel, slave -> master
//     rready                                    R channel, master -> slave
//
//   Modports:
//     master  the refill engine (issues the burst)
//     slave   the memory side (crossbar or test model)
// ---------------------------------------------------------------------------
interface icache_refill_axi_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/icache_refill_axi.sv
// ---------------------------------------------------------------------------
// icache_refill_axi
//   Memory-side responder for icache line refills. A one-cycle miss request
//   is turned into a single AXI4 INCR read burst of BANK_NUM beats; the beats
//   are packed into one line which is handed back with a one-cycle
//   return-enable pulse. Only one refill is in flight at a time.
//
//   Ports:
//     clk, rst_n               clock (posedge) and async active-low reset
//     cache_mem_read_en        miss request pulse from the icache
//     cache_mem_read_addr      miss physical address
//     mem_icache_return_en     one-cycle pulse, refilled line valid
//     mem_icache_return_data   refilled line, word i at [32i+31:32i]
//     refill_busy              high from acceptance through the return pulse
//     refill_err               error status, valid with mem_icache_return_en
//     req_drop                 pulses when a request arrives while busy
//     axi                      AXI4 AR/R channels (master side)
// ---------------------------------------------------------------------------
module icache_refill_axi #(
    parameter int                ADDR_WIDTH = 32,
    parameter int                BANK_NUM   = 8,
    parameter int                BANK_SIZE  = 32,
    parameter int                ID_WIDTH   = 4,
    parameter logic [ID_WIDTH-1:0] AXI_ID   = 4'd0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cache_mem_read_en,
    input  logic [ADDR_WIDTH-1:0]         cache_mem_read_addr,
    output logic                          mem_icache_return_en,
    output logic [BANK_SIZE*BANK_NUM-1:0] mem_icache_return_data,
    output logic                          refill_busy,
    output logic                          refill_err,
    output logic                          req_drop,
    icache_refill_axi_if.master           axi
);

    localparam int CNT_W      = $clog2(BANK_NUM);
    localparam int LINE_BYTES = BANK_NUM * BANK_SIZE / 8;

    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BANK_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AR   = 2'd1;
    localparam logic [1:0] ST_R    = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]                    state;
    logic [CNT_W-1:0]              cnt;
    logic                          err_flag;
    logic [ADDR_WIDTH-1:0]         addr_q;
    logic [BANK_SIZE*BANK_NUM-1:0] line;

    logic beat;
    logic beat_bad;
    logic burst_end;

    // A beat is consumed whenever the slave presents data while we are in R
    // (rready is simply "state is R").
    assign beat = (state == ST_R) && axi.rvalid;

    // Any of: bad response, rlast before the final beat, or no rlast on the
    // final beat marks the line as erroneous.
    assign beat_bad  = beat && ((axi.rresp != 2'b00) ||
                                (axi.rlast != (cnt == LAST_BEAT)));

    // The burst ends on rlast or on the final expected beat, whichever comes
    // first, so a slave that never raises rlast cannot stall the refill.
    assign burst_end = beat && (axi.rlast || (cnt == LAST_BEAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            err_flag <= 1'b0;
            addr_q   <= '0;
            line     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cache_mem_read_en) begin
                        addr_q   <= cache_mem_read_addr & LINE_MASK;
                        cnt      <= '0;
                        err_flag <= 1'b0;
                        state    <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (axi.arready) begin
                        state <= ST_R;
                    end
                end
                ST_R: begin
                    // Words not reached by a short burst keep old contents.
                    if (beat) begin
                        line[32'(cnt)*BANK_SIZE +: BANK_SIZE] <= axi.rdata;
                        cnt <= cnt + 1'b1;
                        if (beat_bad) begin
                            err_flag <= 1'b1;
                        end
                        if (burst_end) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and status outputs decode straight from registered state, so
    // arvalid and the return pulse have no path from any input.
    assign axi.arvalid            = (state == ST_AR);
    assign axi.rready             = (state == ST_R);
    assign mem_icache_return_en   = (state == ST_DONE);
    assign refill_err             = (state == ST_DONE) && err_flag;
    assign refill_busy            = (state != ST_IDLE);
    assign req_drop               = cache_mem_read_en && (state != ST_IDLE);
    assign mem_icache_return_data = line;

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = 8'(BANK_NUM - 1);
    assign axi.arsize  = 3'($clog2(BANK_SIZE / 8));
    assign axi.arburst = 2'b01;

endmodule

// File: tb/tb_icache_refill_axi.sv
// ---------------------------------------------------------------------------
// tb_icache_refill_axi
//   Directed bench for icache_refill_axi. A small memory-slave task answers
//   each burst; the expected line is built from the data the bench sends.
// ---------------------------------------------------------------------------
module tb_icache_refill_axi;

    logic         clk;
    logic         rst_n;
    logic         cache_mem_read_en;
    logic [31:0]  cache_mem_read_addr;
    logic         mem_icache_return_en;
    logic [255:0] mem_icache_return_data;
    logic         refill_busy;
    logic         refill_err;
    logic         req_drop;

    logic [255:0] exp_line;
    int           n_compared;
    int           n_failed;

    icache_refill_axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

    icache_refill_axi dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .cache_mem_read_en      (cache_mem_read_en),
        .cache_mem_read_addr    (cache_mem_read_addr),
        .mem_icache_return_en   (mem_icache_return_en),
        .mem_icache_return_data (mem_icache_return_data),
        .refill_busy            (refill_busy),
        .refill_err             (refill_err),
        .req_drop               (req_drop),
        .axi                    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present a one-cycle miss request.
    task automatic applyStimulus(input logic [31:0] addr);
        cache_mem_read_en   = 1'b1;
        cache_mem_read_addr = addr;
        @(negedge clk);
        cache_mem_read_en   = 1'b0;
    endtask

    // Memory slave: accept the AR after ar_delay cycles, then send n_beats
    // beats of base+b; rlast on beat last_beat, SLVERR on beat err_beat,
    // optional idle gap between beats, optional overlapping request.
    task automatic serveLine(input logic [31:0] base, input int n_beats,
                             input int last_beat, input int err_beat,
                             input bit gap, input int ar_delay, input int drop_at,
                             input bit check_ret, input bit exp_err);
        int          wait_cnt;
        logic [31:0] addr_seen;
        wait_cnt = 0;
        while (bus.arvalid !== 1'b1 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        checkOutput("ar_wait", 256'(bus.arvalid), 256'(1'b1));
        addr_seen = bus.araddr;
        for (int i = 0; i < ar_delay; i++) begin
            @(negedge clk);
            checkOutput("ar_hold_valid", 256'(bus.arvalid), 256'(1'b1));
            checkOutput("ar_hold_addr", 256'(bus.araddr), 256'(addr_seen));
            checkOutput("ar_hold_busy", 256'(refill_busy), 256'(1'b1));
        end
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        checkOutput("ar_done_valid", 256'(bus.arvalid), 256'(1'b0));
        checkOutput("r_ready", 256'(bus.rready), 256'(1'b1));
        for (int b = 0; b < n_beats; b++) begin
            if (gap && b > 0) begin
                bus.rvalid = 1'b0;
                @(negedge clk);
                checkOutput("gap_busy", 256'(refill_busy), 256'(1'b1));
            end
            bus.rvalid = 1'b1;
            bus.rdata  = base + b;
            bus.rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            bus.rlast  = (b == last_beat);
            exp_line[b*32 +: 32] = base + b;
            if (b == drop_at) begin
                cache_mem_read_en   = 1'b1;
                cache_mem_read_addr = 32'h3000_0000;
                #1;
                checkOutput("req_drop_pulse", 256'(req_drop), 256'(1'b1));
            end
            @(negedge clk);
            cache_mem_read_en = 1'b0;
            if (b == drop_at) begin
                #1;
                checkOutput("req_drop_clear", 256'(req_drop), 256'(1'b0));
            end
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
        if (check_ret) begin
            checkOutput("ret_en", 256'(mem_icache_return_en), 256'(1'b1));
            checkOutput("ret_err", 256'(refill_err), 256'(exp_err));
            checkOutput("ret_data", mem_icache_return_data, exp_line);
            checkOutput("ret_busy", 256'(refill_busy), 256'(1'b1));
        end
    endtask

    initial begin
        n_compared          = 0;
        n_failed            = 0;
        exp_line            = '0;
        rst_n               = 1'b0;
        cache_mem_read_en   = 1'b0;
        cache_mem_read_addr = '0;
        bus.arready         = 1'b0;
        bus.rvalid          = 1'b0;
        bus.rdata           = '0;
        bus.rresp           = 2'b00;
        bus.rlast           = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_arvalid", 256'(bus.arvalid), 256'(1'b0));
        checkOutput("rst_rready", 256'(bus.rready), 256'(1'b0));
        checkOutput("rst_ret_en", 256'(mem_icache_return_en), 256'(1'b0));
        checkOutput("rst_busy", 256'(refill_busy), 256'(1'b0));
        checkOutput("rst_err", 256'(refill_err), 256'(1'b0));
        checkOutput("rst_araddr", 256'(bus.araddr), 256'(32'h0));
        checkOutput("rst_data", mem_icache_return_data, 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic refill");
        applyStimulus(32'h1C00_0134);
        checkOutput("b_arvalid_t1", 256'(bus.arvalid), 256'(1'b1));
        checkOutput("b_araddr", 256'(bus.araddr), 256'(32'h1C00_0120));
        checkOutput("b_arlen", 256'(bus.arlen), 256'(8'd7));
        checkOutput("b_arsize", 256'(bus.arsize), 256'(3'd2));
        checkOutput("b_arburst", 256'(bus.arburst), 256'(2'd1));
        checkOutput("b_arid", 256'(bus.arid), 256'(4'd0));
        checkOutput("b_busy", 256'(refill_busy), 256'(1'b1));
        serveLine(32'hA0, 8, 7, -1, 1'b0, 0, -1, 1'b1, 1'b0);
        checkOutput("b_word0", 256'(mem_icache_return_data[31:0]), 256'(32'hA0));
        checkOutput("b_word7", 256'(mem_icache_return_data[255:224]), 256'(32'hA7));
        @(negedge clk);
        checkOutput("b_ret_single", 256'(mem_icache_return_en), 256'(1'b0));
        checkOutput("b_busy_drop", 256'(refill_busy), 256'(1'b0));

        $display("[TB] backpressure and gaps");
        applyStimulus(32'h0000_1008);
        checkOutput("g_araddr", 256'(bus.araddr), 256'(32'h0000_1000));
        serveLine(32'hB0, 8, 7, -1, 1'b1, 3, -1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("g_ret_single", 256'(mem_icache_return_en), 256'(1'b0));

        $display("[TB] error response");
        applyStimulus(32'h0000_2010);
        serveLine(32'hC0, 8, 7, 4, 1'b0, 0, -1, 1'b1, 1'b1);
        checkOutput("e_word4", 256'(mem_icache_return_data[159:128]), 256'(32'hC4));
        cache_mem_read_en   = 1'b1;
        cache_mem_read_addr = 32'h0000_5000;
        #1;
        checkOutput("done_req_drop", 256'(req_drop), 256'(1'b1));
        @(negedge clk);
        cache_mem_read_en = 1'b0;
        checkOutput("done_req_busy", 256'(refill_busy), 256'(1'b0));
        @(negedge clk);
        checkOutput("done_req_no_ar", 256'(bus.arvalid), 256'(1'b0));

        $display("[TB] early rlast");
        applyStimulus(32'h0000_3000);
        serveLine(32'hD0, 6, 5, -1, 1'b0, 0, -1, 1'b1, 1'b1);
        checkOutput("early_word6", 256'(mem_icache_return_data[223:192]), 256'(32'hC6));
        checkOutput("early_word5", 256'(mem_icache_return_data[191:160]), 256'(32'hD5));
        @(negedge clk);

        $display("[TB] missing rlast");
        applyStimulus(32'h0000_4000);
        serveLine(32'hE0, 8, -1, -1, 1'b0, 0, -1, 1'b1, 1'b1);
        checkOutput("nolast_rready", 256'(bus.rready), 256'(1'b0));
        @(negedge clk);
        checkOutput("nolast_rready2", 256'(bus.rready), 256'(1'b0));
        checkOutput("nolast_busy", 256'(refill_busy), 256'(1'b0));

        $display("[TB] overlapping request");
        applyStimulus(32'h2000_0040);
        serveLine(32'hF0, 8, 7, -1, 1'b0, 0, 2, 1'b1, 1'b0);
        checkOutput("ovl_araddr", 256'(bus.araddr), 256'(32'h2000_0040));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("ovl_no_ar", 256'(bus.arvalid), 256'(1'b0));
        end

        $display("[TB] reset mid-burst");
        applyStimulus(32'h0000_0040);
        serveLine(32'h10, 3, -1, -1, 1'b0, 0, -1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("mr_rready", 256'(bus.rready), 256'(1'b0));
        checkOutput("mr_busy", 256'(refill_busy), 256'(1'b0));
        checkOutput("mr_araddr", 256'(bus.araddr), 256'(32'h0));
        checkOutput("mr_data", mem_icache_return_data, 256'(0));
        checkOutput("mr_ret_en", 256'(mem_icache_return_en), 256'(1'b0));
        exp_line = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(32'h0000_0080);
        checkOutput("mr_new_arvalid", 256'(bus.arvalid), 256'(1'b1));
        checkOutput("mr_new_araddr", 256'(bus.araddr), 256'(32'h0000_0080));
        serveLine(32'h20, 8, 7, -1, 1'b0, 0, -1, 1'b1, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
